// File: rtl/cordic_quadrant_ctrl.sv
// Purpose : folds full-circle sin/cos requests into the first quadrant, sequences the
//           first-quadrant CORDIC core and restores the sign of its magnitude result.
// Latency : accept edge to out_valid = 2 + max(CORDIC_LAT, core done) cycles; timeout after TIMEOUT.
// Backpr. : one request in flight; in_ready low from ISSUE until the out_valid/out_ready handshake.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready/in_phase/in_sel   request: [9:8] quadrant, [7:0] angle; sel 0=sin 1=cos
//   out_valid/out_ready/out_value/out_err  signed 9-bit result, err = timeout abort (value 0)
//   busy                           high whenever not IDLE
//   cordic_theta/cordic_s_c/cordic_start   core command (theta/s_c held from ISSUE through WAIT)
//   cordic_done/cordic_value       core completion level and unsigned magnitude
module cordic_quadrant_ctrl #(
    parameter int CORDIC_LAT = 10,
    parameter int TIMEOUT    = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] in_phase,
    input  logic       in_sel,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] out_value,
    output logic       out_err,
    output logic       busy,
    output logic [7:0] cordic_theta,
    output logic       cordic_s_c,
    output logic       cordic_start,
    input  logic       cordic_done,
    input  logic [7:0] cordic_value
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam logic [7:0] LAT_C = 8'(CORDIC_LAT);
    localparam logic [7:0] TMO_C = 8'(TIMEOUT);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] quad;
    logic       sel;
    logic [7:0] cnt;

    logic       done_ok;
    logic       timed_out;
    logic       neg;
    logic [8:0] mag;
    logic [8:0] signed_val;

    // Sign restore: sin is negative in q2/q3, cos is negative in q1/q2.
    // Negating a zero magnitude yields 9'd0, so there is no -0 encoding.
    always_comb begin
        mag        = {1'b0, cordic_value};
        neg        = sel ? (quad[1] ^ quad[0]) : quad[1];
        signed_val = neg ? (9'd0 - mag) : mag;
        // done is a level that may be stale from a previous operation, so it
        // is only trusted once the core's minimum latency has elapsed.
        done_ok    = (cnt >= LAT_C) && cordic_done;
        timed_out  = (cnt == TMO_C);
    end

    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        cordic_start = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cordic_start = 1'b1;
                state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                if (done_ok || timed_out) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            quad         <= 2'd0;
            sel          <= 1'b0;
            cnt          <= 8'd0;
            out_value    <= 9'd0;
            out_err      <= 1'b0;
            cordic_theta <= 8'd0;
            cordic_s_c   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        quad         <= in_phase[9:8];
                        sel          <= in_sel;
                        // Command is latched on accept so it is already stable
                        // in the ISSUE cycle alongside the start pulse.
                        cordic_theta <= in_phase[7:0];
                        // Odd quadrants swap sin and cos in the folded angle.
                        cordic_s_c   <= in_sel ^ in_phase[8];
                    end
                end
                S_ISSUE: begin
                    cnt <= 8'd0;
                end
                S_WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (done_ok) begin
                        out_value <= signed_val;
                        out_err   <= 1'b0;
                    end else if (timed_out) begin
                        out_value <= 9'd0;
                        out_err   <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_quadrant_ctrl.sv
module tb_cordic_quadrant_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [9:0] in_phase = 10'd0;
    logic       in_sel = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [8:0] out_value;
    logic       out_err;
    logic       busy;
    logic [7:0] cordic_theta;
    logic       cordic_s_c;
    logic       cordic_start;
    logic       cordic_done;
    logic [7:0] cordic_value;

    // Core model: done rises model_delay cycles after start and stays high
    // (level) until the next start; model_en=0 models a hung core.
    logic       model_en    = 1'b1;
    logic       model_done  = 1'b0;
    logic       force_done  = 1'b0;
    int         model_cnt   = 0;
    int         model_delay = 3;
    logic [7:0] model_val   = 8'd0;
    int         start_pulses = 0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign cordic_done  = model_done | force_done;
    assign cordic_value = model_val;

    always @(posedge clk) begin
        if (cordic_start) begin
            start_pulses <= start_pulses + 1;
            model_cnt    <= 0;
            model_done   <= 1'b0;
        end else if (model_en && !model_done) begin
            model_cnt <= model_cnt + 1;
            if (model_cnt + 1 >= model_delay) model_done <= 1'b1;
        end
    end

    cordic_quadrant_ctrl #(.CORDIC_LAT(10), .TIMEOUT(63)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_phase     (in_phase),
        .in_sel       (in_sel),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_value    (out_value),
        .out_err      (out_err),
        .busy         (busy),
        .cordic_theta (cordic_theta),
        .cordic_s_c   (cordic_s_c),
        .cordic_start (cordic_start),
        .cordic_done  (cordic_done),
        .cordic_value (cordic_value)
    );

    // Presents a request and returns at the falling edge after it was accepted
    // (DUT then sits in ISSUE).
    task automatic send(input logic [9:0] p, input logic s);
        int n;
        n = 0;
        @(negedge clk);
        in_phase = p;
        in_sel   = s;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({in_ready, out_valid, out_value, out_err, busy, cordic_start, cordic_theta, cordic_s_c} !==
            {1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: rdy=%b ov=%b val=%h err=%b busy=%b st=%b th=%h sc=%b required rdy=1 others 0",
                     in_ready, out_valid, out_value, out_err, busy, cordic_start, cordic_theta, cordic_s_c);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sin_q0();
        int cyc;
        int sp0;
        sp0 = start_pulses;
        model_val = 8'd98;
        send(10'h040, 1'b0);
        total++;
        if ({cordic_start, cordic_theta, cordic_s_c, in_ready, busy} !== {1'b1, 8'd64, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL sin_q0_issue: start=%b theta=%0d sc=%b rdy=%b busy=%b required 1 64 0 0 1",
                     cordic_start, cordic_theta, cordic_s_c, in_ready, busy);
        end
        wait_out(cyc);
        total++;
        if (cyc !== 12) begin
            bad++;
            $display("FAIL sin_q0_latency: got %0d required 12", cyc);
        end
        total++;
        if ({out_value, out_err} !== {9'h062, 1'b0}) begin
            bad++;
            $display("FAIL sin_q0_value: got %h err=%b required 062 err=0", out_value, out_err);
        end
        ack();
        total++;
        if ({out_valid, in_ready, busy} !== 3'b010 || start_pulses - sp0 !== 1) begin
            bad++;
            $display("FAIL sin_q0_done: ov=%b rdy=%b busy=%b starts=%0d required 0 1 0 starts=1",
                     out_valid, in_ready, busy, start_pulses - sp0);
        end
    endtask

    task automatic test_fold_table();
        logic [9:0] ph  [8] = '{10'h240, 10'h140, 10'h180, 10'h3C0, 10'h280, 10'h300, 10'h000, 10'h3FF};
        logic       sl  [8] = '{1'b0,    1'b1,    1'b0,    1'b0,    1'b1,    1'b1,    1'b1,    1'b1};
        logic [7:0] cv  [8] = '{8'd98,   8'd98,   8'd50,   8'd200,  8'd17,   8'd0,    8'd255,  8'd1};
        logic       sc  [8] = '{1'b0,    1'b0,    1'b1,    1'b1,    1'b1,    1'b0,    1'b1,    1'b0};
        logic [8:0] ex  [8] = '{9'h19E,  9'h19E,  9'h032,  9'h138,  9'h1EF,  9'h000,  9'h0FF,  9'h001};
        int cyc;
        for (int i = 0; i < 8; i++) begin
            model_val = cv[i];
            send(ph[i], sl[i]);
            total++;
            if ({cordic_start, cordic_theta, cordic_s_c} !== {1'b1, ph[i][7:0], sc[i]}) begin
                bad++;
                $display("FAIL fold_issue[%0d]: start=%b theta=%h sc=%b required 1 %h %b",
                         i, cordic_start, cordic_theta, cordic_s_c, ph[i][7:0], sc[i]);
            end
            wait_out(cyc);
            total++;
            if (cyc !== 12 || out_value !== ex[i] || out_err !== 1'b0) begin
                bad++;
                $display("FAIL fold_value[%0d]: lat=%0d val=%h err=%b required lat=12 val=%h err=0",
                         i, cyc, out_value, out_err, ex[i]);
            end
            ack();
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        int sp0;
        int errs;
        sp0  = start_pulses;
        errs = 0;
        model_val = 8'd123;
        send(10'h0C0, 1'b0);
        wait_out(cyc);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_phase = 10'($urandom_range(0, 1023));
            @(negedge clk);
            if ({out_valid, out_value, in_ready, cordic_start} !== {1'b1, 9'd123, 1'b0, 1'b0}) errs++;
        end
        in_valid = 1'b0;
        total++;
        if (errs !== 0) begin
            bad++;
            $display("FAIL backpressure_hold: %0d unstable cycles required 0", errs);
        end
        total++;
        if (start_pulses - sp0 !== 1) begin
            bad++;
            $display("FAIL backpressure_starts: got %0d required 1", start_pulses - sp0);
        end
        ack();
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL backpressure_release: ov=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        model_en = 1'b0;
        send(10'h040, 1'b0);
        wait_out(cyc);
        total++;
        if (cyc !== 65 || out_err !== 1'b1 || out_value !== 9'd0) begin
            bad++;
            $display("FAIL timeout_abort: lat=%0d err=%b val=%h required lat=65 err=1 val=000",
                     cyc, out_err, out_value);
        end
        ack();
        total++;
        if (out_err !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL timeout_clear: err=%b ov=%b required 0 0", out_err, out_valid);
        end
        model_en  = 1'b1;
        model_val = 8'd9;
        send(10'h100, 1'b0);
        wait_out(cyc);
        total++;
        if (cyc !== 12 || out_value !== 9'h009 || out_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_recover: lat=%0d val=%h err=%b required 12 009 0", cyc, out_value, out_err);
        end
        ack();
    endtask

    task automatic test_reset_mid_wait();
        int cyc;
        int seen;
        model_en = 1'b0;
        send(10'h040, 1'b0);
        repeat (6) @(negedge clk);
        rst        = 1'b1;
        force_done = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, out_valid, out_value, out_err, busy, cordic_start, cordic_theta, cordic_s_c} !==
            {1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0}) begin
            bad++;
            $display("FAIL midwait_reset: rdy=%b ov=%b val=%h err=%b busy=%b st=%b th=%h sc=%b required rdy=1 others 0",
                     in_ready, out_valid, out_value, out_err, busy, cordic_start, cordic_theta, cordic_s_c);
        end
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL midwait_dropped: %0d cycles with activity required 0", seen);
        end
        model_val = 8'd77;
        send(10'h000, 1'b0);
        wait_out(cyc);
        total++;
        if (cyc !== 12 || out_value !== 9'd77) begin
            bad++;
            $display("FAIL stale_done: lat=%0d val=%h required lat=12 val=04d", cyc, out_value);
        end
        ack();
        force_done = 1'b0;
        model_en   = 1'b1;
    endtask

    task automatic test_back_to_back();
        int cyc;
        model_val = 8'd40;
        send(10'h020, 1'b1);
        wait_out(cyc);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_phase  = 10'h2AA;
        in_sel    = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if ({in_ready, busy, cordic_start, out_valid} !== 4'b1000) begin
            bad++;
            $display("FAIL b2b_idle_gap: rdy=%b busy=%b start=%b ov=%b required 1 0 0 0",
                     in_ready, busy, cordic_start, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if ({cordic_start, cordic_theta, cordic_s_c} !== {1'b1, 8'hAA, 1'b0}) begin
            bad++;
            $display("FAIL b2b_issue: start=%b theta=%h sc=%b required 1 aa 0", cordic_start, cordic_theta, cordic_s_c);
        end
        wait_out(cyc);
        total++;
        if (cyc !== 12 || out_value !== 9'h1D8) begin
            bad++;
            $display("FAIL b2b_value: lat=%0d val=%h required 12 1d8", cyc, out_value);
        end
        ack();
    endtask

    initial begin
        test_reset();
        test_sin_q0();
        test_fold_table();
        test_backpressure();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
